// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the fire dispatcher and its synapse banks.
// A synapse entry pairs a target neuron with a signed weight.
package ucaspian_pkg;

    localparam int SYN_BANKS  = 4;
    localparam int SYN_ADDR_W = 10;
    localparam int TARGET_W   = 8;
    localparam int WEIGHT_W   = 8;

    typedef struct packed {
        logic [TARGET_W-1:0]        target;
        logic signed [WEIGHT_W-1:0] weight;
    } synapse_t;

endpackage

// File: rtl/synapse_bank_if.sv
// Synapse bank ports: dispatcher address channel, config write,
// and the output channel towards the dendrite accumulator.
interface synapse_bank_if
    import ucaspian_pkg::*;
#(
    parameter int ADDR_W = SYN_ADDR_W
);

    logic                       enable;
    logic [ADDR_W-1:0]          syn_addr;
    logic                       syn_vld;
    logic                       syn_rdy;
    logic                       cfg_wr_en;
    logic [ADDR_W-1:0]          cfg_addr;
    logic [TARGET_W-1:0]        cfg_target;
    logic signed [WEIGHT_W-1:0] cfg_weight;
    logic                       out_vld;
    logic                       out_rdy;
    logic [TARGET_W-1:0]        out_target;
    logic signed [WEIGHT_W-1:0] out_weight;
    logic                       idle;

    modport master (
        output enable, syn_addr, syn_vld,
        output cfg_wr_en, cfg_addr, cfg_target, cfg_weight,
        output out_rdy,
        input  syn_rdy, out_vld, out_target, out_weight, idle
    );

    modport slave (
        input  enable, syn_addr, syn_vld,
        input  cfg_wr_en, cfg_addr, cfg_target, cfg_weight,
        input  out_rdy,
        output syn_rdy, out_vld, out_target, out_weight, idle
    );

endinterface

// File: rtl/synapse_mem.sv
// Single-port synchronous synapse RAM, one-cycle read, write-first.
// Kept standalone so a vendor BRAM macro can replace it.
module synapse_mem
    import ucaspian_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = SYN_ADDR_W
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  synapse_t          i_wdata,
    output synapse_t          o_rdata
);

    synapse_t r_mem [DEPTH];
    synapse_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
                r_rdata       <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/synapse_bank.sv
// One synapse bank: address in, memory lookup, zero-weight filter,
// small output FIFO towards the dendrite accumulator.
module synapse_bank
    import ucaspian_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = SYN_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    synapse_bank_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    synapse_t          r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_pending;

    logic [OCC_W-1:0]  w_occ;
    logic              w_syn_rdy;
    logic              w_accept;
    logic              w_mem_en;
    logic [ADDR_W-1:0] w_mem_addr;
    synapse_t          w_wdata;
    synapse_t          w_rd_data;
    logic              w_push;
    logic              w_pop;
    logic              w_out_vld;
    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;

    // Reserve a FIFO slot for the read in flight, so nothing is ever lost.
    assign w_occ     = OCC_W'(r_count) + OCC_W'(r_rd_pending);
    assign w_syn_rdy = bus.enable && !reset && !bus.cfg_wr_en
                       && (w_occ < OCC_W'(FIFO_DEPTH));
    assign w_accept  = bus.syn_vld && w_syn_rdy;

    assign w_mem_en   = w_accept || bus.cfg_wr_en;
    assign w_mem_addr = bus.cfg_wr_en ? bus.cfg_addr : bus.syn_addr;
    assign w_wdata    = '{target: bus.cfg_target, weight: bus.cfg_weight};

    synapse_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (bus.cfg_wr_en),
        .i_addr  (w_mem_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rd_data)
    );

    assign w_push    = r_rd_pending && (w_rd_data.weight != '0);
    assign w_out_vld = (r_count != '0);
    assign w_pop     = w_out_vld && bus.out_rdy;

    assign w_wr_nxt = (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1))
                      ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_nxt = (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1))
                      ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pending <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_rd_pending <= w_accept;
            if (w_push) r_wr_ptr <= w_wr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && r_count == CNT_W'(FIFO_DEPTH)))
                else $error("synapse_bank: push to full FIFO");
            assert (!(w_pop && r_count == '0))
                else $error("synapse_bank: pop from empty FIFO");
        end
    end

    assign bus.syn_rdy    = w_syn_rdy;
    assign bus.out_vld    = w_out_vld;
    assign bus.out_target = r_fifo[r_rd_ptr].target;
    assign bus.out_weight = r_fifo[r_rd_ptr].weight;
    assign bus.idle       = !r_rd_pending && (r_count == '0);

endmodule

// File: tb/tb_synapse_bank.sv
// Bench for synapse_bank: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_synapse_bank;
    import ucaspian_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    synapse_bank_if #(.ADDR_W(10)) bus_if ();

    synapse_bank #(
        .DEPTH      (1024),
        .ADDR_W     (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, $signed(act), $signed(exp), $time);
        end
    endtask

    // Reference model: results in order, each visible 2 cycles after accept
    typedef struct {
        logic [7:0]        t;
        logic signed [7:0] w;
        int                vis;
    } exp_t;

    exp_t     q[$];
    synapse_t m_mem [1024];
    bit       model_on = 1'b0;
    bit       acc_last = 1'b0;
    int       cyc = 0;

    int pops = 0, run = 0, max_run = 0;
    int first_pop = -1, last_pop = -1;

    always @(negedge clk) begin
        int   cnt;
        bit   vld_e, rdy_e, acc;
        exp_t e;
        cyc++;
        if (model_on) begin
            cnt = 0;
            foreach (q[i]) if (q[i].vis <= cyc) cnt++;
            vld_e = (cnt != 0);
            rdy_e = bus_if.enable && !reset && !bus_if.cfg_wr_en
                    && (cnt + int'(acc_last)) < 4;
            chk("m_syn_rdy", 32'(bus_if.syn_rdy), 32'(rdy_e));
            chk("m_out_vld", 32'(bus_if.out_vld), 32'(vld_e));
            chk("m_idle", 32'(bus_if.idle), 32'(!acc_last && cnt == 0));
            if (vld_e) begin
                chk("m_target", 32'(bus_if.out_target), 32'(q[0].t));
                chk("m_weight", 32'(bus_if.out_weight), 32'(q[0].w));
            end
            if (bus_if.out_vld && bus_if.out_rdy) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            run = bus_if.out_vld ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (reset) begin
                q.delete();
                acc_last = 1'b0;
            end else begin
                if (vld_e && bus_if.out_rdy) void'(q.pop_front());
                acc = bus_if.syn_vld && rdy_e;
                if (acc && m_mem[bus_if.syn_addr].weight != 0) begin
                    e.t   = m_mem[bus_if.syn_addr].target;
                    e.w   = m_mem[bus_if.syn_addr].weight;
                    e.vis = cyc + 2;
                    q.push_back(e);
                end
                if (bus_if.cfg_wr_en)
                    m_mem[bus_if.cfg_addr] = '{target: bus_if.cfg_target,
                                               weight: bus_if.cfg_weight};
                acc_last = acc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int a, input int t, input int w);
        bus_if.cfg_wr_en  = 1'b1;
        bus_if.cfg_addr   = 10'(a);
        bus_if.cfg_target = 8'(t);
        bus_if.cfg_weight = 8'(w);
        tick();
        bus_if.cfg_wr_en  = 1'b0;
    endtask

    int addrs[$];
    int sent;

    task automatic offer(input int budget, output int ncyc);
        bit r;
        ncyc = 0;
        while (sent < addrs.size() && ncyc < budget) begin
            bus_if.syn_vld  = 1'b1;
            bus_if.syn_addr = 10'(addrs[sent]);
            @(negedge clk);
            r = bus_if.syn_rdy;
            tick();
            if (r) sent++;
            ncyc++;
        end
        bus_if.syn_vld = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_if.idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus_if.idle), 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset             = 1'b1;
        bus_if.enable     = 1'b1;
        bus_if.syn_vld    = 1'b0;
        bus_if.syn_addr   = '0;
        bus_if.cfg_wr_en  = 1'b0;
        bus_if.cfg_addr   = '0;
        bus_if.cfg_target = '0;
        bus_if.cfg_weight = '0;
        bus_if.out_rdy    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_syn_rdy", 32'(bus_if.syn_rdy), 32'd0);
        tick();
        reset    = 1'b0;
        model_on = 1'b1;
        @(negedge clk);
        chk("rst_idle", 32'(bus_if.idle), 32'd1);
        chk("rst_out_vld", 32'(bus_if.out_vld), 32'd0);
        chk("rst_syn_rdy_after", 32'(bus_if.syn_rdy), 32'd1);
        tick();

        for (int i = 0; i < 8; i++) prog(i, i * 3 + 1, i + 1);
        prog(5, 12, -3);

        // Single lookup: 2-cycle latency
        bus_if.out_rdy  = 1'b1;
        bus_if.syn_vld  = 1'b1;
        bus_if.syn_addr = 10'd5;
        @(negedge clk);
        chk("t1_rdy", 32'(bus_if.syn_rdy), 32'd1);
        tick();
        bus_if.syn_vld = 1'b0;
        @(negedge clk);
        chk("t1_vld_early", 32'(bus_if.out_vld), 32'd0);
        @(negedge clk);
        chk("t1_vld", 32'(bus_if.out_vld), 32'd1);
        chk("t1_target", 32'(bus_if.out_target), 32'd12);
        chk("t1_weight", 32'(bus_if.out_weight), -32'sd3);
        @(negedge clk);
        chk("t1_idle", 32'(bus_if.idle), 32'd1);
        tick();

        // Full-rate stream
        pops = 0; max_run = 0;
        addrs = {0, 1, 2, 3, 4, 5, 6, 7};
        sent = 0;
        offer(20, n);
        chk("t2_cycles", 32'(n), 32'd8);
        drain("t2_drain", 20);
        chk("t2_pops", 32'(pops), 32'd8);
        chk("t2_run", 32'(max_run), 32'd8);

        // Backpressure
        bus_if.out_rdy = 1'b0;
        pops = 0;
        addrs = {0, 1, 2, 3, 4, 5};
        sent = 0;
        offer(10, n);
        chk("t3_accepted", 32'(sent), 32'd4);
        @(negedge clk);
        chk("t3_rdy_low", 32'(bus_if.syn_rdy), 32'd0);
        tick();
        bus_if.out_rdy = 1'b1;
        offer(20, n);
        chk("t3_sent", 32'(sent), 32'd6);
        drain("t3_drain", 30);
        chk("t3_pops", 32'(pops), 32'd6);

        // Enable gating
        bus_if.enable = 1'b0;
        addrs = {3};
        sent = 0;
        offer(3, n);
        chk("en_blocked", 32'(sent), 32'd0);
        bus_if.enable = 1'b1;
        offer(5, n);
        chk("en_sent", 32'(sent), 32'd1);
        drain("en_drain", 10);

        // Zero-weight drop
        prog(1, 41, 5);
        prog(2, 42, 0);
        prog(3, 43, -7);
        prog(4, 44, 127);
        pops = 0; first_pop = -1;
        addrs = {1, 2, 3, 4};
        sent = 0;
        offer(10, n);
        drain("t4_drain", 20);
        chk("t4_pops", 32'(pops), 32'd3);
        chk("t4_span", 32'(last_pop - first_pop), 32'd3);

        // Config write collides with address offer
        bus_if.syn_vld    = 1'b1;
        bus_if.syn_addr   = 10'd9;
        bus_if.cfg_wr_en  = 1'b1;
        bus_if.cfg_addr   = 10'd9;
        bus_if.cfg_target = 8'd99;
        bus_if.cfg_weight = 8'd55;
        @(negedge clk);
        chk("t5_rdy_blocked", 32'(bus_if.syn_rdy), 32'd0);
        tick();
        bus_if.cfg_wr_en = 1'b0;
        @(negedge clk);
        chk("t5_rdy", 32'(bus_if.syn_rdy), 32'd1);
        tick();
        bus_if.syn_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_vld", 32'(bus_if.out_vld), 32'd1);
        chk("t5_target", 32'(bus_if.out_target), 32'd99);
        chk("t5_weight", 32'(bus_if.out_weight), 32'd55);
        tick();
        drain("t5_drain", 10);

        // Reset with 3 buffered and one read pending
        bus_if.out_rdy = 1'b0;
        addrs = {5, 6, 7, 0};
        sent = 0;
        offer(8, n);
        chk("t6_accepted", 32'(sent), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy_vld", 32'(bus_if.out_vld), 32'd1);
        chk("t6_busy_idle", 32'(bus_if.idle), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_post_vld", 32'(bus_if.out_vld), 32'd0);
        chk("t6_post_idle", 32'(bus_if.idle), 32'd1);
        tick();
        bus_if.out_rdy = 1'b1;
        addrs = {6};
        sent = 0;
        offer(5, n);
        @(negedge clk);
        @(negedge clk);
        chk("t6_mem_target", 32'(bus_if.out_target), 32'd19);
        chk("t6_mem_weight", 32'(bus_if.out_weight), 32'd7);
        tick();
        drain("t6_drain", 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
